obj_mem_arbiter: RTL and testbench
==================================

// Module: obj_mem_arbiter
// PURPOSE
//  Shares the single-port object memory between matrix_top (read/write, loadback) and
//  clipping_top (read-only). Sits between both requesters and video_mem_unit, replacing
//  the two dedicated ports. Provides a req/gnt handshake, registered memory drive,
//  tagged read-data return, a frame lock and anti-starvation for the clipper.
// PARAMETERS
//  DATA_W      144  object record width
//  ADDR_W      5    object address width (32 slots)
//  RD_LAT      1    memory read latency: cycles from mem_en to valid mem_rdata (1..4)
//  STARVE_MAX  4    max consecutive matrix grants while clip_req is pending
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous reset, active-high
//  mat_req     in   1       matrix access request; hold until granted
//  mat_we      in   1       1 = write, 0 = read
//  mat_addr    in   ADDR_W  matrix address
//  mat_wdata   in   DATA_W  matrix write data
//  mat_gnt     out  1       matrix request accepted this cycle
//  mat_rvld    out  1       matrix read data valid (1-cycle pulse)
//  clip_req    in   1       clipper read request; hold until granted
//  clip_addr   in   ADDR_W  clipper address
//  clip_lock   in   1       clipper frame read in progress: blocks matrix writes
//  clip_gnt    out  1       clipper request accepted this cycle
//  clip_rvld   out  1       clipper read data valid (1-cycle pulse)
//  rdata       out  DATA_W  read data, shared; qualified by *_rvld
//  mem_en      out  1       memory access strobe (registered)
//  mem_we      out  1       memory write enable (registered)
//  mem_addr    out  ADDR_W  memory address (registered)
//  mem_wdata   out  DATA_W  memory write data (registered)
//  mem_rdata   in   DATA_W  memory read data
//  arb_busy    out  1       any access in flight or any request pending
// BEHAVIOUR
//  Reset: mem_en, mem_we, mem_addr, mem_wdata, the rvld pipeline, starve_cnt and owner
//   tags clear to 0. Consequently mat_rvld=clip_rvld=0 and arb_busy=0 until a request arrives.
//  gnt is combinational from req and state. An access is accepted on any cycle where req&gnt=1.
//   A requester may change addr/data or drop req only after an accepted cycle.
//  At most one gnt per cycle. Eligibility:
//   mat eligible  = mat_req & ~(mat_we & clip_lock) & ~force_clip
//   clip eligible = clip_req
//   force_clip    = clip_req & (starve_cnt == STARVE_MAX)
//  Priority: force_clip -> clip; else mat if eligible; else clip if eligible.
//  starve_cnt: +1 on a mat grant while clip_req=1 (saturates at STARVE_MAX);
//   cleared on a clip grant or when clip_req=0.
//  Accept in cycle c -> mem_en=1 in cycle c+1, with mem_we/addr/wdata from the winner.
//   For clip, mem_we=0 and mem_wdata holds its previous value. Back-to-back accepts give
//   mem_en high on consecutive cycles (full throughput, no bubbles).
//  Reads: a tag pipeline of depth RD_LAT+1 carries {valid, owner}. The owner's rvld pulses in
//   cycle c+1+RD_LAT; rdata = mem_rdata that cycle. Return order equals accept order.
//   Writes produce no rvld.
//  Write-then-read to the same address, accepted in consecutive cycles, returns the new data
//   (memory is in-order single-port; no forwarding needed).
//  clip_lock rising while a mat write is pending: the write stalls (mat_gnt=0) until the
//   lock falls. Mat reads continue during the lock. A write already accepted before the
//   lock completes normally.
//  Simultaneous mat_req & clip_req with no starvation: mat wins. clip wins on the next free
//   cycle, or after STARVE_MAX mat grants.
//  arb_busy = mat_req | clip_req | mem_en | any tag-pipeline valid bit.
//  rst asserted mid-operation: in-flight reads are discarded (no rvld after reset), no
//   gnt is asserted during the rst cycle, and the memory is not re-driven.
// TESTING
//  1. mat write addr 3 data A5.., then mat read addr 3 (RD_LAT=1) -> mem_en cycles c+1,c+2;
//     mat_rvld in cycle c+3 with rdata=A5...
//  2. mat_req and clip_req held continuously (STARVE_MAX=4) -> grant pattern M,M,M,M,C repeating.
//  3. clip_lock=1, mat write pending for 10 cycles -> mat_gnt=0 throughout; mat_gnt=1 in the
//     cycle clip_lock falls; clip reads granted meanwhile.
//  4. Interleaved reads mat@1, clip@2, mat@4 back-to-back, RD_LAT=3 -> rvld pulses in
//     consecutive cycles, owners M,C,M, data matching the memory model.
//  5. rst pulsed 1 cycle after 2 reads are accepted -> no rvld ever appears;
//     arb_busy=0 the cycle after reset.
//  6. Idle with no requests -> mem_en=0, gnt=0, arb_busy=0 for 100 cycles.

Source files
------------

// File: rtl/obj_mem_arbiter.sv
// rtl/obj_mem_arbiter.sv - shared object memory arbiter for matrix and clipper requesters
module obj_mem_arbiter #(
  parameter int DATA_W     = 144,
  parameter int ADDR_W     = 5,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mat_req,
  input  logic              mat_we,
  input  logic [ADDR_W-1:0] mat_addr,
  input  logic [DATA_W-1:0] mat_wdata,
  output logic              mat_gnt,
  output logic              mat_rvld,
  input  logic              clip_req,
  input  logic [ADDR_W-1:0] clip_addr,
  input  logic              clip_lock,
  output logic              clip_gnt,
  output logic              clip_rvld,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int DEPTH = RD_LAT + 1;

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  // Tag pipeline: stage k is visible k+1 cycles after the accept; owner 1 = clipper.
  logic [DEPTH-1:0]  tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0]  tag_own_q, tag_own_d;

  logic force_clip;
  logic mat_elig;

  // Grant selection: starved clipper first, then matrix, then clipper; nothing during reset.
  always_comb begin
    force_clip = clip_req && (starve_cnt_q == CNT_W'(STARVE_MAX));
    mat_elig   = mat_req && !(mat_we && clip_lock) && !force_clip;
    mat_gnt    = !rst && mat_elig;
    clip_gnt   = !rst && clip_req && !mat_elig;
  end

  // Next-state for the starvation counter, registered memory drive and read tags.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!clip_req || clip_gnt) begin
      starve_cnt_d = '0;
    end else if (mat_gnt && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    mem_en_d    = mat_gnt || clip_gnt;
    mem_we_d    = mat_gnt && mat_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (mat_gnt) begin
      mem_addr_d  = mat_addr;
      mem_wdata_d = mat_wdata;
    end else if (clip_gnt) begin
      mem_addr_d  = clip_addr;
    end

    tag_vld_d = {tag_vld_q[DEPTH-2:0], (mat_gnt && !mat_we) || clip_gnt};
    tag_own_d = {tag_own_q[DEPTH-2:0], clip_gnt};
  end

  // State registers with synchronous reset; reset also flushes in-flight read tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tag_vld_q    <= '0;
      tag_own_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
    end
  end

  // Output decode; a return landing in the reset cycle is suppressed.
  always_comb begin
    mem_en    = mem_en_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    rdata     = mem_rdata;
    mat_rvld  = !rst && tag_vld_q[RD_LAT] && !tag_own_q[RD_LAT];
    clip_rvld = !rst && tag_vld_q[RD_LAT] && tag_own_q[RD_LAT];
    arb_busy  = mat_req || clip_req || mem_en_q || (|tag_vld_q);
  end

endmodule

// File: tb/tb_obj_mem_arbiter.sv
// tb/tb_obj_mem_arbiter.sv - directed self-checking bench for obj_mem_arbiter
module tb_obj_mem_arbiter;
  localparam int DW = 144;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mat_req, mat_we, clip_req, clip_lock;
  logic [AW-1:0] mat_addr, clip_addr;
  logic [DW-1:0] mat_wdata;

  logic          m1_mat_gnt, m1_mat_rvld, m1_clip_gnt, m1_clip_rvld, m1_mem_en, m1_mem_we, m1_busy;
  logic [AW-1:0] m1_mem_addr;
  logic [DW-1:0] m1_rdata, m1_mem_wdata, m1_mem_rdata;
  logic          m3_mat_gnt, m3_mat_rvld, m3_clip_gnt, m3_clip_rvld, m3_mem_en, m3_mem_we, m3_busy;
  logic [AW-1:0] m3_mem_addr;
  logic [DW-1:0] m3_rdata, m3_mem_wdata, m3_mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  obj_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .mat_req(mat_req), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
    .mat_gnt(m1_mat_gnt), .mat_rvld(m1_mat_rvld),
    .clip_req(clip_req), .clip_addr(clip_addr), .clip_lock(clip_lock),
    .clip_gnt(m1_clip_gnt), .clip_rvld(m1_clip_rvld), .rdata(m1_rdata),
    .mem_en(m1_mem_en), .mem_we(m1_mem_we), .mem_addr(m1_mem_addr), .mem_wdata(m1_mem_wdata),
    .mem_rdata(m1_mem_rdata), .arb_busy(m1_busy)
  );

  obj_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .mat_req(mat_req), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
    .mat_gnt(m3_mat_gnt), .mat_rvld(m3_mat_rvld),
    .clip_req(clip_req), .clip_addr(clip_addr), .clip_lock(clip_lock),
    .clip_gnt(m3_clip_gnt), .clip_rvld(m3_clip_rvld), .rdata(m3_rdata),
    .mem_en(m3_mem_en), .mem_we(m3_mem_we), .mem_addr(m3_mem_addr), .mem_wdata(m3_mem_wdata),
    .mem_rdata(m3_mem_rdata), .arb_busy(m3_busy)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    logic [35:0] w;
    w = 36'(i) ^ 36'hF0F00A5C3;
    return {w, w, w, w};
  endfunction

  // Memory model: one array, 1-cycle read port for dut, 3-cycle read port for dut3.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] p0, p1, p2;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (m1_mem_en && m1_mem_we) begin
      mem[m1_mem_addr] <= m1_mem_wdata;
    end
    if (m1_mem_en && !m1_mem_we) m1_mem_rdata <= mem[m1_mem_addr];
    if (m3_mem_en && !m3_mem_we) p0 <= mem[m3_mem_addr];
    p1 <= p0;
    p2 <= p1;
  end
  assign m3_mem_rdata = p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mat_req = 1'b0; mat_we = 1'b0; mat_addr = '0; mat_wdata = '0;
    clip_req = 1'b0; clip_addr = '0; clip_lock = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({m1_mem_en, m1_mem_we, m1_mat_rvld, m1_clip_rvld, m1_busy} !== 5'b0)
      $display("FAIL reset_ctrl got en=%b we=%b mrv=%b crv=%b busy=%b want all 0",
               m1_mem_en, m1_mem_we, m1_mat_rvld, m1_clip_rvld, m1_busy);
    else n_pass++;
    n_total++;
    if (m1_mem_addr !== '0 || m1_mem_wdata !== '0)
      $display("FAIL reset_data got addr=%0d wdata=%h want 0", m1_mem_addr, m1_mem_wdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] a5;
    a5 = {18{8'hA5}};
    mat_req = 1'b1; mat_we = 1'b1; mat_addr = 5'd3; mat_wdata = a5;
    @(negedge clk);
    n_total++;
    if (m1_mat_gnt !== 1'b1 || m1_clip_gnt !== 1'b0 || m1_busy !== 1'b1)
      $display("FAIL wr_accept got gnt=%b cgnt=%b busy=%b want 1 0 1", m1_mat_gnt, m1_clip_gnt, m1_busy);
    else n_pass++;
    tick();
    mat_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (m1_mat_gnt !== 1'b1 || m1_mem_en !== 1'b1 || m1_mem_we !== 1'b1 ||
        m1_mem_addr !== 5'd3 || m1_mem_wdata !== a5)
      $display("FAIL wr_drive got gnt=%b en=%b we=%b addr=%0d wdata=%h", m1_mat_gnt, m1_mem_en,
               m1_mem_we, m1_mem_addr, m1_mem_wdata);
    else n_pass++;
    tick();
    mat_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (m1_mem_en !== 1'b1 || m1_mem_we !== 1'b0 || m1_mat_rvld !== 1'b0)
      $display("FAIL rd_drive got en=%b we=%b rvld=%b want 1 0 0", m1_mem_en, m1_mem_we, m1_mat_rvld);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (m1_mat_rvld !== 1'b1 || m1_clip_rvld !== 1'b0 || m1_rdata !== a5)
      $display("FAIL rd_return got rvld=%b crvld=%b rdata=%h want 1 0 %h", m1_mat_rvld,
               m1_clip_rvld, m1_rdata, a5);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (m1_mat_rvld !== 1'b0 || m1_mem_en !== 1'b0)
      $display("FAIL rd_pulse got rvld=%b en=%b want 0 0", m1_mat_rvld, m1_mem_en);
    else n_pass++;
    tick();
    repeat (4) tick();
  endtask

  task automatic test_starvation();
    logic exp_c;
    mat_req = 1'b1; mat_we = 1'b0; mat_addr = 5'd0;
    clip_req = 1'b1; clip_addr = 5'd1;
    for (int i = 0; i < 10; i++) begin
      exp_c = ((i % 5) == 4);
      @(negedge clk);
      n_total++;
      if (m1_mat_gnt !== !exp_c || m1_clip_gnt !== exp_c)
        $display("FAIL starve_cycle%0d got mgnt=%b cgnt=%b want %b %b", i, m1_mat_gnt,
                 m1_clip_gnt, !exp_c, exp_c);
      else n_pass++;
      tick();
    end
    clear_inputs();
    repeat (6) tick();
  endtask

  task automatic test_lock();
    clip_lock = 1'b1;
    mat_req = 1'b1; mat_we = 1'b1; mat_addr = 5'd7; mat_wdata = {9{16'h1234}};
    clip_req = 1'b1; clip_addr = 5'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_total++;
      if (m1_mat_gnt !== 1'b0 || m1_clip_gnt !== 1'b1)
        $display("FAIL lock_cycle%0d got mgnt=%b cgnt=%b want 0 1", i, m1_mat_gnt, m1_clip_gnt);
      else n_pass++;
      tick();
    end
    clip_lock = 1'b0; clip_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (m1_mat_gnt !== 1'b1)
      $display("FAIL lock_release got mgnt=%b want 1", m1_mat_gnt);
    else n_pass++;
    tick();
    clip_lock = 1'b1; mat_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (m1_mat_gnt !== 1'b1 || m1_mem_we !== 1'b1 || m1_mem_addr !== 5'd7)
      $display("FAIL lock_read got mgnt=%b we=%b addr=%0d want 1 1 7", m1_mat_gnt, m1_mem_we, m1_mem_addr);
    else n_pass++;
    tick();
    clear_inputs();
    repeat (8) tick();
  endtask

  task automatic test_interleave();
    logic [DW-1:0] exp_d [3];
    logic          exp_clip [3];
    exp_d[0] = init_word(1); exp_d[1] = init_word(2); exp_d[2] = init_word(4);
    exp_clip[0] = 1'b0; exp_clip[1] = 1'b1; exp_clip[2] = 1'b0;
    mat_req = 1'b1; mat_we = 1'b0; mat_addr = 5'd1;
    @(negedge clk);
    n_total++;
    if (m3_mat_gnt !== 1'b1) $display("FAIL il_acc0 got mgnt=%b want 1", m3_mat_gnt);
    else n_pass++;
    tick();
    mat_req = 1'b0; clip_req = 1'b1; clip_addr = 5'd2;
    @(negedge clk);
    n_total++;
    if (m3_clip_gnt !== 1'b1) $display("FAIL il_acc1 got cgnt=%b want 1", m3_clip_gnt);
    else n_pass++;
    tick();
    clip_req = 1'b0; mat_req = 1'b1; mat_addr = 5'd4;
    @(negedge clk);
    n_total++;
    if (m3_mat_gnt !== 1'b1) $display("FAIL il_acc2 got mgnt=%b want 1", m3_mat_gnt);
    else n_pass++;
    tick();
    mat_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (m3_mat_rvld !== 1'b0 || m3_clip_rvld !== 1'b0)
      $display("FAIL il_early got mrv=%b crv=%b want 0 0", m3_mat_rvld, m3_clip_rvld);
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (m3_mat_rvld !== !exp_clip[i] || m3_clip_rvld !== exp_clip[i] || m3_rdata !== exp_d[i])
        $display("FAIL il_ret%0d got mrv=%b crv=%b rdata=%h want %b %b %h", i, m3_mat_rvld,
                 m3_clip_rvld, m3_rdata, !exp_clip[i], exp_clip[i], exp_d[i]);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_total++;
    if (m3_mat_rvld !== 1'b0 || m3_clip_rvld !== 1'b0)
      $display("FAIL il_late got mrv=%b crv=%b want 0 0", m3_mat_rvld, m3_clip_rvld);
    else n_pass++;
    tick();
    repeat (3) tick();
  endtask

  task automatic test_reset_midop();
    mat_req = 1'b1; mat_we = 1'b0; mat_addr = 5'd5;
    tick();
    mat_req = 1'b0; clip_req = 1'b1; clip_addr = 5'd6;
    tick();
    clip_req = 1'b0; rst = 1'b1; mat_req = 1'b1; mat_addr = 5'd5;
    @(negedge clk);
    n_total++;
    if (m1_mat_gnt !== 1'b0 || m1_clip_gnt !== 1'b0 || m1_mat_rvld !== 1'b0)
      $display("FAIL rst_cycle got mgnt=%b cgnt=%b mrv=%b want 0 0 0", m1_mat_gnt, m1_clip_gnt, m1_mat_rvld);
    else n_pass++;
    tick();
    rst = 1'b0; mat_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (m1_busy !== 1'b0 || m1_mem_en !== 1'b0)
      $display("FAIL rst_after got busy=%b en=%b want 0 0", m1_busy, m1_mem_en);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if ({m1_mat_rvld, m1_clip_rvld, m3_mat_rvld, m3_clip_rvld} !== 4'b0)
        $display("FAIL rst_norvld%0d got %b%b%b%b want 0000", i, m1_mat_rvld, m1_clip_rvld,
                 m3_mat_rvld, m3_clip_rvld);
      else n_pass++;
      tick();
      @(negedge clk);
    end
    tick();
  endtask

  task automatic test_idle();
    clear_inputs();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_total++;
      if ({m1_mem_en, m1_mat_gnt, m1_clip_gnt, m1_busy} !== 4'b0)
        $display("FAIL idle%0d got en=%b mgnt=%b cgnt=%b busy=%b want 0", i, m1_mem_en,
                 m1_mat_gnt, m1_clip_gnt, m1_busy);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_write_read();
    test_starvation();
    test_lock();
    test_interleave();
    test_reset_midop();
    test_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
